sram_test_monitor: RTL

Downstream status/capture stage for the SRAM tester. Consumes the tester's round-done and pass flags plus its debug buses (address, pattern state, expected and read data). Counts pass/fail rounds, latches a failure snapshot for the PMOD LEDs, and drives human-visible LEDs: a stretched activity pulse and a wait/pass/fail status indication. Sits between the tester instance and the board LED/PMOD assignments in the top level.

---
 rtl/sram_test_monitor.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sram_test_monitor.sv
// sram_test_monitor: status/capture stage behind the SRAM tester.
// Counts pass and fail rounds and latches a failure snapshot for the PMOD LEDs.
// It also drives a stretched activity LED and a wait/pass/fail (blinking) status LED.
// Optional build macro SRAM_MONITOR_LAST_FAIL_EN: every fail event overwrites the
// snapshot. Without the macro, the first failure is kept.
module sram_test_monitor #(
    parameter int ADDR_BITS    = 20,
    parameter int DATA_BITS    = 16,
    parameter int STRETCH_BITS = 22,
    parameter int COUNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  test_done,
    input  logic                  test_pass,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [2:0]            pattern_state,
    input  logic [DATA_BITS-1:0]  expected_data,
    input  logic [DATA_BITS-1:0]  read_data,
    output logic                  led_activity,
    output logic                  led_status,
    output logic                  fail_valid,
    output logic [ADDR_BITS-1:0]  fail_addr,
    output logic [2:0]            fail_pattern,
    output logic [DATA_BITS-1:0]  fail_expected,
    output logic [DATA_BITS-1:0]  fail_read,
    output logic [COUNT_BITS-1:0] pass_count,
    output logic [COUNT_BITS-1:0] fail_count
);

    typedef enum logic [1:0] {S_WAIT, S_PASS, S_FAIL} state_t;

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [STRETCH_BITS-1:0] stretch_cnt_q, stretch_cnt_d;
    logic [STRETCH_BITS-1:0] blink_cnt_q, blink_cnt_d;
    logic [COUNT_BITS-1:0]   pass_count_q, pass_count_d;
    logic [COUNT_BITS-1:0]   fail_count_q, fail_count_d;
    logic                    fail_valid_q, fail_valid_d;
    logic [ADDR_BITS-1:0]    fail_addr_q, fail_addr_d;
    logic [2:0]              fail_pattern_q, fail_pattern_d;
    logic [DATA_BITS-1:0]    fail_expected_q, fail_expected_d;
    logic [DATA_BITS-1:0]    fail_read_q, fail_read_d;
    logic                    done_evt, fail_evt, capture;

    // Edge detection, counters, snapshot capture and next state
    always_comb begin
        done_evt        = test_done & ~done_q;
        fail_evt        = ~test_pass & pass_q;
        done_d          = test_done;
        pass_d          = test_pass;
        blink_cnt_d     = blink_cnt_q + 1'b1;
        stretch_cnt_d   = stretch_cnt_q;
        pass_count_d    = pass_count_q;
        fail_count_d    = fail_count_q;
        fail_valid_d    = fail_valid_q;
        fail_addr_d     = fail_addr_q;
        fail_pattern_d  = fail_pattern_q;
        fail_expected_d = fail_expected_q;
        fail_read_d     = fail_read_q;
        state_d         = state_q;

        // Retrigger reloads the stretch; otherwise count down to idle
        if (done_evt)
            stretch_cnt_d = '1;
        else if (stretch_cnt_q != '0)
            stretch_cnt_d = stretch_cnt_q - 1'b1;

        if (done_evt && test_pass && (pass_count_q != '1))
            pass_count_d = pass_count_q + 1'b1;

        if (fail_evt && (fail_count_q != '1))
            fail_count_d = fail_count_q + 1'b1;

`ifdef SRAM_MONITOR_LAST_FAIL_EN
        capture = fail_evt;
`else
        capture = fail_evt & ~fail_valid_q;
`endif
        if (capture) begin
            fail_addr_d     = addr;
            fail_pattern_d  = pattern_state;
            fail_expected_d = expected_data;
            fail_read_d     = read_data;
        end
        if (fail_evt)
            fail_valid_d = 1'b1;

        // A failure outranks a same-cycle pass; S_FAIL is left only by reset/clear
        case (state_q)
            S_WAIT: begin
                if (fail_evt)
                    state_d = S_FAIL;
                else if (done_evt && test_pass)
                    state_d = S_PASS;
            end
            S_PASS: if (fail_evt) state_d = S_FAIL;
            S_FAIL: state_d = S_FAIL;
            default: state_d = S_WAIT;
        endcase

        // Clear drops any same-cycle event; done_q follows the level so a held
        // test_done is not seen as a new round afterwards
        if (clear) begin
            done_d          = test_done;
            pass_d          = 1'b1;
            stretch_cnt_d   = '0;
            pass_count_d    = '0;
            fail_count_d    = '0;
            fail_valid_d    = 1'b0;
            fail_addr_d     = '0;
            fail_pattern_d  = '0;
            fail_expected_d = '0;
            fail_read_d     = '0;
            state_d         = S_WAIT;
        end
    end

    // State register; blink counter is only touched by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_WAIT;
            done_q          <= 1'b0;
            pass_q          <= 1'b1;
            stretch_cnt_q   <= '0;
            blink_cnt_q     <= '0;
            pass_count_q    <= '0;
            fail_count_q    <= '0;
            fail_valid_q    <= 1'b0;
            fail_addr_q     <= '0;
            fail_pattern_q  <= '0;
            fail_expected_q <= '0;
            fail_read_q     <= '0;
        end else begin
            state_q         <= state_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            stretch_cnt_q   <= stretch_cnt_d;
            blink_cnt_q     <= blink_cnt_d;
            pass_count_q    <= pass_count_d;
            fail_count_q    <= fail_count_d;
            fail_valid_q    <= fail_valid_d;
            fail_addr_q     <= fail_addr_d;
            fail_pattern_q  <= fail_pattern_d;
            fail_expected_q <= fail_expected_d;
            fail_read_q     <= fail_read_d;
        end
    end

    // Status LED decode from the registered state and blink counter
    always_comb begin
        led_status = 1'b0;
        case (state_q)
            S_PASS:  led_status = 1'b1;
            S_FAIL:  led_status = blink_cnt_q[STRETCH_BITS-1];
            default: led_status = 1'b0;
        endcase
    end

    assign led_activity  = (stretch_cnt_q != '0);
    assign fail_valid    = fail_valid_q;
    assign fail_addr     = fail_addr_q;
    assign fail_pattern  = fail_pattern_q;
    assign fail_expected = fail_expected_q;
    assign fail_read     = fail_read_q;
    assign pass_count    = pass_count_q;
    assign fail_count    = fail_count_q;

endmodule
